// File: rtl/d_cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
// Default field widths match the default parameters (2-bit offset, 2-bit index, 12-bit tag).
package d_cache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    RESPOND = 2'd2,
    WRITE   = 2'd3
  } state_t;

  localparam int DEF_WORD_SIZE   = 16;
  localparam int DEF_LINE_WORDS  = 4;
  localparam int DEF_NUM_LINES   = 4;
  localparam int DEF_MEM_LATENCY = 2;
  localparam int DEF_OFF_W       = $clog2(DEF_LINE_WORDS);
  localparam int DEF_IDX_W       = $clog2(DEF_NUM_LINES);
  localparam int DEF_TAG_W       = DEF_WORD_SIZE - DEF_OFF_W - DEF_IDX_W;

  // Helpers work on a 32-bit view so any parameterisation can share them;
  // callers cast the result down to the field width.
  function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int off_w);
    return addr & ((32'd1 << off_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int off_w,
                                             input int idx_w);
    return (addr >> off_w) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int off_w,
                                           input int idx_w);
    return addr >> (off_w + idx_w);
  endfunction

endpackage

// File: rtl/d_cache_if.sv
// CPU data-port bundle of the data cache; the CPU is master, the cache is slave.
interface d_cache_if #(
  parameter int WORD_SIZE = 16
) ();

  logic                 cpu_read;
  logic                 cpu_write;
  logic [WORD_SIZE-1:0] cpu_addr;
  logic [WORD_SIZE-1:0] cpu_wdata;
  logic [WORD_SIZE-1:0] cpu_rdata;
  logic                 cpu_ready;

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready
  );

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready
  );

endinterface

// File: rtl/d_cache_mem_beat.sv
// Memory beat timing for the data cache: beat counter, beat-done flag, d_data
// tri-state driver and the capture register holding the requested fill word.
module d_cache_mem_beat #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 active,
  input  logic                 drive,
  input  logic                 capture,
  input  logic [WORD_SIZE-1:0] wdata,
  inout  wire  [WORD_SIZE-1:0] d_data,
  output logic                 beat_done,
  output logic [WORD_SIZE-1:0] rdata,
  output logic [WORD_SIZE-1:0] cap_q
);

  localparam int CNT_W = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign beat_done = active && (cnt_q == CNT_W'(MEM_LATENCY));
  assign d_data    = drive ? wdata : {WORD_SIZE{1'bz}};
  assign rdata     = d_data;

  // Counter parks at zero outside FILL/WRITE so every beat starts from zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      cap_q <= '0;
    end else begin
      if (!active || beat_done) cnt_q <= '0;
      else                      cnt_q <= cnt_q + 1'b1;
      if (capture && beat_done) cap_q <= d_data;
    end
  end

endmodule

// File: rtl/d_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Optional statistics counters are built only when D_CACHE_STATS_EN is defined.
//
// state   | meaning
// IDLE    | waiting; read hits answered combinationally
// FILL    | reading the missed line from memory, one beat per word
// RESPOND | returning the requested word of the freshly filled line
// WRITE   | driving a write through to memory; updates the line on a hit
module d_cache #(
  parameter int WORD_SIZE   = 16,
  parameter int LINE_WORDS  = 4,
  parameter int NUM_LINES   = 4,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  d_cache_if.slave             cpu,
  output logic                 d_readM,
  output logic                 d_writeM,
  output logic [WORD_SIZE-1:0] d_address,
  inout  wire  [WORD_SIZE-1:0] d_data
`ifdef D_CACHE_STATS_EN
  ,
  output logic [15:0]          hit_count,
  output logic [15:0]          access_count
`endif
);

  import d_cache_pkg::*;

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;

  state_t state_q, state_d;

  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [OFF_W-1:0]     k_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [WORD_SIZE-1:0] data_mem [NUM_LINES][LINE_WORDS];

  logic [OFF_W-1:0] req_off, cap_off;
  logic [IDX_W-1:0] req_idx, cap_idx;
  logic [TAG_W-1:0] req_tag, cap_tag;
  logic             req_hit, cap_hit;

  logic                 accept, start_fill, fill_we, line_done, wr_hit_done;
  logic                 beat_active, beat_done, capture;
  logic [WORD_SIZE-1:0] mem_rdata, cap_word;

  // Live request fields decode the bus in IDLE; captured fields are used afterwards.
  assign req_off = OFF_W'(addr_offset(32'(cpu.cpu_addr), OFF_W));
  assign req_idx = IDX_W'(addr_index(32'(cpu.cpu_addr), OFF_W, IDX_W));
  assign req_tag = TAG_W'(addr_tag(32'(cpu.cpu_addr), OFF_W, IDX_W));
  assign cap_off = OFF_W'(addr_offset(32'(addr_q), OFF_W));
  assign cap_idx = IDX_W'(addr_index(32'(addr_q), OFF_W, IDX_W));
  assign cap_tag = TAG_W'(addr_tag(32'(addr_q), OFF_W, IDX_W));

  assign req_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign cap_hit = valid_q[cap_idx] && (tag_mem[cap_idx] == cap_tag);

  assign beat_active = (state_q == FILL) || (state_q == WRITE);
  assign capture     = (state_q == FILL) && (k_q == cap_off);

  d_cache_mem_beat #(
    .WORD_SIZE   (WORD_SIZE),
    .MEM_LATENCY (MEM_LATENCY)
  ) u_beat (
    .clk       (clk),
    .reset_n   (reset_n),
    .active    (beat_active),
    .drive     (state_q == WRITE),
    .capture   (capture),
    .wdata     (wdata_q),
    .d_data    (d_data),
    .beat_done (beat_done),
    .rdata     (mem_rdata),
    .cap_q     (cap_word)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    cpu.cpu_ready = 1'b0;
    cpu.cpu_rdata = '0;
    d_readM       = 1'b0;
    d_writeM      = 1'b0;
    d_address     = '0;
    accept        = 1'b0;
    start_fill    = 1'b0;
    fill_we       = 1'b0;
    line_done     = 1'b0;
    wr_hit_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu.cpu_write) begin
          accept  = 1'b1;
          state_d = WRITE;
        end else if (cpu.cpu_read) begin
          if (req_hit) begin
            cpu.cpu_ready = 1'b1;
            cpu.cpu_rdata = data_mem[req_idx][req_off];
          end else begin
            accept     = 1'b1;
            start_fill = 1'b1;
            state_d    = FILL;
          end
        end
      end
      FILL: begin
        d_readM   = 1'b1;
        d_address = {cap_tag, cap_idx, k_q};
        if (beat_done) begin
          fill_we = 1'b1;
          if (k_q == OFF_W'(LINE_WORDS - 1)) begin
            line_done = 1'b1;
            state_d   = RESPOND;
          end
        end
      end
      RESPOND: begin
        cpu.cpu_ready = 1'b1;
        cpu.cpu_rdata = cap_word;
        state_d       = IDLE;
      end
      WRITE: begin
        d_writeM  = 1'b1;
        d_address = addr_q;
        if (beat_done) begin
          cpu.cpu_ready = 1'b1;
          wr_hit_done   = cap_hit;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The target line is invalidated when its fill starts, so an aborted fill leaves it invalid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      k_q     <= '0;
      valid_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= cpu.cpu_addr;
        wdata_q <= cpu.cpu_wdata;
      end
      if (state_q != FILL) k_q <= '0;
      else if (beat_done)  k_q <= k_q + 1'b1;
      if (start_fill)      valid_q[req_idx] <= 1'b0;
      else if (line_done)  valid_q[cap_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we)     data_mem[cap_idx][k_q]     <= mem_rdata;
    if (wr_hit_done) data_mem[cap_idx][cap_off] <= wdata_q;
    if (line_done)   tag_mem[cap_idx]           <= cap_tag;
  end

`ifdef D_CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_count    <= '0;
      access_count <= '0;
    end else begin
      if (cpu.cpu_ready) access_count <= access_count + 16'd1;
      if (((state_q == IDLE) && cpu.cpu_ready) || wr_hit_done)
        hit_count <= hit_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_d_cache.sv
// Directed self-checking bench for d_cache with a latency-aware memory model.
module tb_d_cache;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  d_cache_if #(.WORD_SIZE(16)) cpu ();

  logic        d_readM, d_writeM;
  logic [15:0] d_address;
  wire  [15:0] d_data;
`ifdef D_CACHE_STATS_EN
  logic [15:0] hit_count, access_count;
`endif

  d_cache #(
    .WORD_SIZE(16), .LINE_WORDS(4), .NUM_LINES(4), .MEM_LATENCY(LAT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu       (cpu),
    .d_readM   (d_readM),
    .d_writeM  (d_writeM),
    .d_address (d_address),
    .d_data    (d_data)
`ifdef D_CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .access_count (access_count)
`endif
  );

  // Memory model: initial contents from pat(), overridden by observed writes.
  logic [15:0]   wmem [0:1023];
  logic [1023:0] wvalid = '0;

  function automatic logic [15:0] pat(input logic [15:0] a);
    case (a)
      16'h0024: return 16'h6100;
      16'h0025: return 16'hf41c;
      16'h0026: return 16'h6200;
      16'h0027: return 16'hf81c;
      default:  return a ^ 16'hC3C3;
    endcase
  endfunction

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return wvalid[a[9:0]] ? wmem[a[9:0]] : pat(a);
  endfunction

  // Data is only valid once the address has been held for LAT prior cycles.
  logic        prev_rd = 1'b0;
  logic [15:0] prev_addr = '0;
  int          run = 0;
  int          cur_run;
  always_comb cur_run = (prev_rd && prev_addr == d_address) ? run + 1 : 0;
  assign d_data = d_readM ? ((cur_run >= LAT) ? mem_val(d_address) : 16'h0BAD) : 16'hzzzz;

  int          rd_cycles = 0, wr_cycles = 0;
  logic        overlap = 1'b0;
  logic [15:0] addr_log [0:255];
  logic [15:0] last_wr_addr = '0;

  always @(posedge clk) begin
    prev_rd   <= d_readM;
    prev_addr <= d_address;
    run       <= cur_run;
    if (d_readM) begin
      addr_log[rd_cycles[7:0]] <= d_address;
      rd_cycles <= rd_cycles + 1;
    end
    if (d_writeM) begin
      wmem[d_address[9:0]]   <= d_data;
      wvalid[d_address[9:0]] <= 1'b1;
      wr_cycles    <= wr_cycles + 1;
      last_wr_addr <= d_address;
    end
    if (d_readM && d_writeM) overlap <= 1'b1;
  end

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the cycle the request is first presented; cyc is the cycle of cpu_ready.
  task automatic cpu_req(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wd, output int cyc, output logic [15:0] rdata);
    @(negedge clk);
    cpu.cpu_read  = rd;
    cpu.cpu_write = wr;
    cpu.cpu_addr  = addr;
    cpu.cpu_wdata = wd;
    cyc   = 0;
    rdata = '0;
    #1;
    while (!cpu.cpu_ready && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (cpu.cpu_ready) rdata = cpu.cpu_rdata;
    @(posedge clk);
    #1;
    cpu.cpu_read  = 1'b0;
    cpu.cpu_write = 1'b0;
  endtask

  int          cyc, base;
  logic [15:0] rd;

  initial begin
    cpu.cpu_read  = 1'b0;
    cpu.cpu_write = 1'b0;
    cpu.cpu_addr  = '0;
    cpu.cpu_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(cpu.cpu_ready), 0);
    chk("rst_rdata", 32'(cpu.cpu_rdata), 0);
    chk("rst_readM", 32'(d_readM), 0);
    chk("rst_writeM", 32'(d_writeM), 0);
    chk("rst_addr", 32'(d_address), 0);
`ifdef D_CACHE_STATS_EN
    chk("rst_hits", 32'(hit_count), 0);
    chk("rst_acc", 32'(access_count), 0);
`endif
    reset_n = 1'b1;

    base = rd_cycles;
    cpu_req(1'b1, 1'b0, 16'h0025, 16'h0, cyc, rd);
    chk("cold_lat", cyc, 13);
    chk("cold_data", 32'(rd), 32'hf41c);
    chk("cold_beats", rd_cycles - base, 12);
    for (int i = 0; i < 12; i++) chk("cold_addr", 32'(addr_log[base + i]), 32'h24 + i / 3);

    base = rd_cycles;
    cpu_req(1'b1, 1'b0, 16'h0026, 16'h0, cyc, rd);
    chk("reread_lat", cyc, 0);
    chk("reread_data", 32'(rd), 32'h6200);
    chk("reread_noread", rd_cycles - base, 0);

    base = wr_cycles;
    cpu_req(1'b0, 1'b1, 16'h0026, 16'hBEEF, cyc, rd);
    chk("wrhit_lat", cyc, 3);
    chk("wrhit_beats", wr_cycles - base, 3);
    chk("wrhit_addr", 32'(last_wr_addr), 32'h26);
    chk("wrhit_mem", 32'(mem_val(16'h0026)), 32'hBEEF);
    cpu_req(1'b1, 1'b0, 16'h0026, 16'h0, cyc, rd);
    chk("wrhit_rd_lat", cyc, 0);
    chk("wrhit_rd_data", 32'(rd), 32'hBEEF);
`ifdef D_CACHE_STATS_EN
    chk("stats_hits1", 32'(hit_count), 3);
    chk("stats_acc1", 32'(access_count), 4);
`endif

    cpu_req(1'b1, 1'b0, 16'h0020, 16'h0, cyc, rd);
    chk("l0_fill_lat", cyc, 13);
    chk("l0_fill_data", 32'(rd), 32'hC3E3);
    base = wr_cycles;
    cpu_req(1'b0, 1'b1, 16'h0100, 16'h1234, cyc, rd);
    chk("wrmiss_lat", cyc, 3);
    chk("wrmiss_beats", wr_cycles - base, 3);
    chk("wrmiss_mem", 32'(mem_val(16'h0100)), 32'h1234);
`ifdef D_CACHE_STATS_EN
    chk("stats_hits2", 32'(hit_count), 3);
    chk("stats_acc2", 32'(access_count), 6);
`endif
    cpu_req(1'b1, 1'b0, 16'h0020, 16'h0, cyc, rd);
    chk("noalloc_lat", cyc, 0);
    chk("noalloc_data", 32'(rd), 32'hC3E3);
    cpu_req(1'b1, 1'b0, 16'h0100, 16'h0, cyc, rd);
    chk("rdmiss100_lat", cyc, 13);
    chk("rdmiss100_data", 32'(rd), 32'h1234);
    cpu_req(1'b1, 1'b0, 16'h0020, 16'h0, cyc, rd);
    chk("replaced_lat", cyc, 13);

    // Reset in cycle 5 of a fill of 0x0040 (second beat, word 0x41).
    @(negedge clk);
    cpu.cpu_read = 1'b1;
    cpu.cpu_addr = 16'h0040;
    repeat (5) @(negedge clk);
    #1;
    chk("abort_readM", 32'(d_readM), 1);
    chk("abort_addr", 32'(d_address), 32'h41);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ready", 32'(cpu.cpu_ready), 0);
    chk("abort_readM0", 32'(d_readM), 0);
    chk("abort_addr0", 32'(d_address), 0);
    chk("abort_rdata", 32'(cpu.cpu_rdata), 0);
`ifdef D_CACHE_STATS_EN
    chk("abort_hits", 32'(hit_count), 0);
    chk("abort_acc", 32'(access_count), 0);
`endif
    cpu.cpu_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cpu_req(1'b1, 1'b0, 16'h0040, 16'h0, cyc, rd);
    chk("after_abort_lat", cyc, 13);
    chk("after_abort_data", 32'(rd), 32'hC383);

    cpu_req(1'b1, 1'b0, 16'h0010, 16'h0, cyc, rd);
    chk("conf1_lat", cyc, 13);
    chk("conf1_data", 32'(rd), 32'hC3D3);
    cpu_req(1'b1, 1'b0, 16'h0050, 16'h0, cyc, rd);
    chk("conf2_lat", cyc, 13);
    chk("conf2_data", 32'(rd), 32'hC393);
    cpu_req(1'b1, 1'b0, 16'h0010, 16'h0, cyc, rd);
    chk("conf3_lat", cyc, 13);
    chk("conf3_data", 32'(rd), 32'hC3D3);

    cpu_req(1'b1, 1'b1, 16'h0011, 16'h7777, cyc, rd);
    chk("rw_write_wins", cyc, 3);
    cpu_req(1'b1, 1'b0, 16'h0011, 16'h0, cyc, rd);
    chk("rw_rd_lat", cyc, 0);
    chk("rw_rd_data", 32'(rd), 32'h7777);
`ifdef D_CACHE_STATS_EN
    chk("stats_hits3", 32'(hit_count), 2);
    chk("stats_acc3", 32'(access_count), 6);
`endif
    chk("no_overlap", 32'(overlap), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/d_cache.md
# d_cache

Direct-mapped, write-through, no-write-allocate data cache between the CPU data port and the data side of the fixed-latency unified memory. Read hits complete in zero wait cycles. Read misses fill a whole line word by word over the memory's multi-cycle data interface. Writes always go through to memory.

## Interface
Parameters:
- WORD_SIZE, 16, data/address width
- LINE_WORDS, 4, words per line (power of 2)
- NUM_LINES, 4, number of lines (power of 2)
- MEM_LATENCY, 2, memory cycles before data is valid

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- cpu_read  in  1  read request; held until cpu_ready
- cpu_write  in  1  write request; held until cpu_ready
- cpu_addr  in  WORD_SIZE  word address
- cpu_wdata  in  WORD_SIZE  write data
- cpu_rdata  out  WORD_SIZE  read data, valid when cpu_ready && cpu_read
- cpu_ready  out  1  request completes this cycle
- d_readM  out  1  memory read strobe
- d_writeM  out  1  memory write strobe
- d_address  out  WORD_SIZE  memory word address
- d_data  inout  WORD_SIZE  driven by cache only while d_writeM, else high-Z
- hit_count, access_count  out  16 each  present only with D_CACHE_STATS_EN

## Operation
- Address split: offset = addr[log2(LINE_WORDS)-1:0], index = next log2(NUM_LINES) bits, tag = remaining bits. Defaults give 2/2/12.
- Per line: valid bit, tag, LINE_WORDS data words.
- States: IDLE, FILL, RESPOND, WRITE.
- IDLE, cpu_read, hit (valid && tag match): cpu_ready=1 combinationally; cpu_rdata = line word; stay IDLE.
- IDLE, cpu_read, miss: go to FILL with beat k=0.
- IDLE, cpu_write: go to WRITE. If cpu_read and cpu_write are both high, the write wins.
- FILL:
  - Beat k drives d_readM=1 and d_address={tag,index,k} for MEM_LATENCY+1 cycles.
  - d_data is captured into word k on the last cycle of the beat.
  - After beat LINE_WORDS-1: set valid, write the tag, go to RESPOND.
  - The valid bit stays 0 throughout FILL.
- RESPOND: cpu_ready=1, cpu_rdata = filled word at the requested offset; go to IDLE.
- WRITE:
  - Drives d_writeM=1, d_address=cpu_addr, d_data=cpu_wdata for MEM_LATENCY+1 cycles.
  - On the last cycle: cpu_ready=1. On a hit, the cached word is updated; on a miss, no allocation. Then go to IDLE.
- A beat counter runs 0..MEM_LATENCY and clears on every beat and state change.

## Timing
- Reset: state=IDLE, all valid bits 0, counters 0, cpu_ready=0, cpu_rdata=0, d_readM=0, d_writeM=0, d_address=0, d_data=Z, stats=0.
- Read hit: latency 0; cpu_ready is high in the request cycle.
- Read miss (request seen in cycle 0): FILL occupies cycles 1..LINE_WORDS*(MEM_LATENCY+1); RESPOND follows. Defaults: cpu_ready in cycle 13.
- Write (request seen in cycle 0): WRITE occupies cycles 1..MEM_LATENCY+1; cpu_ready in the last one. Defaults: cycle 3.
- d_readM and d_writeM are never high together. d_address is stable for a whole beat.
- The CPU must hold request, address and data until cpu_ready. Changes mid-transaction are ignored: the captured address and data are used.
- Reset mid-FILL or mid-WRITE: abort immediately to the reset state. The partially filled line stays invalid.
- Back-to-back requests: a request present in the cycle after cpu_ready is accepted normally from IDLE.

## Configuration
- D_CACHE_STATS_EN defined:
  - access_count increments once per completed CPU request (cycle with cpu_ready=1).
  - hit_count increments on read hits in IDLE and on write hits.
  - Both counters wrap at 16 bits.
- D_CACHE_STATS_EN undefined: the ports and counters do not exist. Functional behaviour is identical.

## Structure
- Package d_cache_pkg: the state enum (IDLE, FILL, RESPOND, WRITE), address field width constants derived from the parameters, and the tag/index/offset extraction functions.
- Sub-module d_cache_mem_beat: beat counter, beat-done flag, d_data tri-state driver and capture register. Instantiated once.

## Test plan
- Cold read 0x0025 with memory[0x24..0x27] = 6100, f41c, 6200, f81c:
  - d_address steps 0x24..0x27, 3 cycles each.
  - cpu_ready in cycle 13 with cpu_rdata=f41c.
- Re-read 0x0026 after the first test: cpu_ready in the same cycle, rdata=6200, no d_readM.
- Write 0x0026 := 0xBEEF (hit):
  - d_writeM for 3 cycles with d_address=0x26, cpu_ready in cycle 3.
  - A subsequent read of 0x0026 hits with BEEF.
- Write 0x0100 (miss):
  - The memory write occurs.
  - A read of 0x0100 then misses and fills.
  - Line index 0 previously holding tag 0x002 is replaced and the stats hit count is unchanged.
- Reset asserted in cycle 5 of a fill of 0x0040: all outputs return to reset values; the next read of 0x0040 misses again.
- Conflict: read 0x0010, then read 0x0050 (same index 0, different tag), then 0x0010: three misses, each 13 cycles.
